// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle fetch/decode/execute sequencer with a data-memory handshake and timeout
module cpu_ctrl_fsm #(
    parameter int PC_W    = 9,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     inst_data,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     ir,
    output logic [2:0]      rf_addr1,
    output logic [2:0]      rf_addr2,
    output logic [8:0]      imm,
    output logic            reg_we,
    output logic [1:0]      wb_sel,
    output logic            mem_req,
    output logic            mem_we,
    output logic [8:0]      mem_addr,
    input  logic            mem_ack,
    output logic            mdr_load,
    output logic            halted,
    output logic            illegal,
    output logic            bus_err
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM_WAIT, WB, HALT} state_t;
    state_t     state;
    logic [7:0] cnt;
    logic [3:0] op;
    assign op       = ir[15:12];
    assign rf_addr1 = ir[11:9];
    assign rf_addr2 = ir[8:6];
    assign imm      = ir[8:0];
    assign mem_addr = ir[8:0];
    // strobes decode from state and ir only; mdr_load is the one path from an input
    assign reg_we   = (state == WB) || (state == EXEC && (op == 4'd1 || op == 4'd4));
    assign wb_sel   = (state == WB) ? 2'd2 : (state == EXEC && op == 4'd4) ? 2'd1 : 2'd0;
    assign mem_req  = state == MEM_WAIT;
    assign mem_we   = mem_req && op == 4'd3;
    assign mdr_load = mem_req && op == 4'd2 && mem_ack;
    assign halted   = state == HALT;
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= '0;
            ir      <= '0;
            cnt     <= '0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            case (state)
                FETCH: state <= DECODE;
                DECODE: begin
                    ir    <= inst_data;
                    pc    <= pc + 1'b1;
                    state <= EXEC;
                end
                EXEC: begin
                    state <= FETCH;
                    if (op == 4'd2 || op == 4'd3) begin
                        cnt   <= '0;
                        state <= MEM_WAIT;
                    end
                    if (op == 4'd5) pc <= PC_W'(ir[8:0]);
                    if (op == 4'd6) state <= HALT;
                    if (op > 4'd6) illegal <= 1'b1;
                end
                MEM_WAIT: begin
                    if (mem_ack) state <= (op == 4'd2) ? WB : FETCH;
                    else if (cnt == 8'(TIMEOUT - 1)) begin
                        bus_err <= 1'b1;
                        state   <= HALT;
                    end else cnt <= cnt + 1'b1;
                end
                WB: state <= FETCH;
                HALT: state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: per-cycle scoreboard of expected ir/pc/strobe snapshots for cpu_ctrl_fsm
module tb_cpu_ctrl_fsm;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] inst_data;
    logic [8:0]  pc;
    logic [15:0] ir;
    logic [2:0]  rf_addr1, rf_addr2;
    logic [8:0]  imm, mem_addr;
    logic        reg_we, mem_req, mem_we, mem_ack, mdr_load, halted, illegal, bus_err;
    logic [1:0]  wb_sel;
    logic [15:0] rom [512];
    int checks = 0;
    int errors = 0;

    // flag layout: {reg_we, wb_sel[1:0], mem_req, mem_we, mdr_load, halted, illegal, bus_err}
    localparam logic [8:0] NONE = 9'h000, ADDW = 9'h100, LIW = 9'h140, WBW = 9'h180;
    localparam logic [8:0] LDR = 9'h020, LDA = 9'h028, STR = 9'h030;
    localparam logic [8:0] HLT = 9'h004, ILF = 9'h002, BEF = 9'h001;

    typedef struct {
        bit          r;
        bit          a;
        logic [33:0] v;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    logic [33:0] obs;
    assign obs = {ir, pc, reg_we, wb_sel, mem_req, mem_we, mdr_load, halted, illegal, bus_err};

    cpu_ctrl_fsm dut (
        .clk(clk), .rst(rst), .inst_data(inst_data), .pc(pc), .ir(ir),
        .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .imm(imm), .reg_we(reg_we),
        .wb_sel(wb_sel), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mdr_load(mdr_load), .halted(halted), .illegal(illegal),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;
    always_ff @(posedge clk) inst_data <= rom[pc];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic p(input bit r, input bit a, input logic [15:0] xir, input logic [8:0] xpc,
                     input logic [8:0] fl);
        exp_t x;
        x.r = r;
        x.a = a;
        x.v = {xir, xpc, fl};
        sb.push_back(x);
    endtask

    task automatic load_rom(input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3);
        for (int i = 0; i < 512; i++) rom[i] = 16'h0000;
        rom[0] = w0;
        rom[1] = w1;
        rom[2] = w2;
        rom[3] = w3;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        mem_ack = 1'b1;
        do_reset();
        #1;
        checks++;
        if (obs !== 34'h0) begin
            errors++;
            $display("FAIL reset_state got %h exp %h", obs, 34'h0);
        end
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (pc !== 9'd0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_decode pc got %0d exp 0 req got %b exp 0", pc, mem_req);
        end
    endtask

    task automatic test_add();
        int n = 0;
        load_rom(16'h1240, 16'h0000, 16'h0000, 16'h0000);
        do_reset();
        p(0, 0, 16'h0000, 0, NONE);
        p(0, 0, 16'h0000, 0, NONE);
        p(0, 0, 16'h1240, 1, ADDW);
        p(0, 0, 16'h1240, 1, NONE);
        p(0, 0, 16'h1240, 1, NONE);
        p(0, 0, 16'h0000, 2, NONE);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst = e.r;
            mem_ack = e.a;
            #1;
            checks++;
            if (obs !== e.v) begin
                errors++;
                $display("FAIL add cyc%0d got %h exp %h", n, obs, e.v);
            end
            if (n == 2) begin
                checks++;
                if ({rf_addr1, rf_addr2} !== 6'o11) begin
                    errors++;
                    $display("FAIL add_fields got %o exp 11", {rf_addr1, rf_addr2});
                end
            end
            n++;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_li_jmp();
        int n = 0;
        load_rom(16'h4205, 16'h5003, 16'h6000, 16'h4207);
        do_reset();
        p(0, 0, 16'h0000, 0, NONE);
        p(0, 0, 16'h0000, 0, NONE);
        p(0, 0, 16'h4205, 1, LIW);
        p(0, 0, 16'h4205, 1, NONE);
        p(0, 0, 16'h4205, 1, NONE);
        p(0, 0, 16'h5003, 2, NONE);
        p(0, 0, 16'h5003, 3, NONE);
        p(0, 0, 16'h5003, 3, NONE);
        p(0, 0, 16'h4207, 4, LIW);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst = e.r;
            mem_ack = e.a;
            #1;
            checks++;
            if (obs !== e.v) begin
                errors++;
                $display("FAIL li_jmp cyc%0d got %h exp %h", n, obs, e.v);
            end
            if (n == 2) begin
                checks++;
                if (imm !== 9'd5) begin
                    errors++;
                    $display("FAIL li_imm got %0d exp 5", imm);
                end
            end
            n++;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_load();
        int n = 0;
        load_rom(16'h2A10, 16'h0000, 16'h0000, 16'h0000);
        do_reset();
        p(0, 0, 16'h0000, 0, NONE);
        p(0, 0, 16'h0000, 0, NONE);
        p(0, 1, 16'h2A10, 1, NONE);
        p(0, 0, 16'h2A10, 1, LDR);
        p(0, 0, 16'h2A10, 1, LDR);
        p(0, 1, 16'h2A10, 1, LDA);
        p(0, 0, 16'h2A10, 1, WBW);
        p(0, 1, 16'h2A10, 1, NONE);
        p(0, 0, 16'h2A10, 1, NONE);
        p(0, 0, 16'h0000, 2, NONE);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst = e.r;
            mem_ack = e.a;
            #1;
            checks++;
            if (obs !== e.v) begin
                errors++;
                $display("FAIL load cyc%0d got %h exp %h", n, obs, e.v);
            end
            if (n == 3) begin
                checks++;
                if (mem_addr !== 9'h010) begin
                    errors++;
                    $display("FAIL load_addr got %h exp 010", mem_addr);
                end
            end
            n++;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_store_timeout();
        int n = 0;
        load_rom(16'h3205, 16'h0000, 16'h0000, 16'h0000);
        do_reset();
        p(0, 0, 16'h0000, 0, NONE);
        p(0, 0, 16'h0000, 0, NONE);
        p(0, 0, 16'h3205, 1, NONE);
        for (int i = 0; i < 15; i++) p(0, 0, 16'h3205, 1, STR);
        for (int i = 0; i < 20; i++) p(0, i[0], 16'h3205, 1, HLT | BEF);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst = e.r;
            mem_ack = e.a;
            #1;
            checks++;
            if (obs !== e.v) begin
                errors++;
                $display("FAIL store_to cyc%0d got %h exp %h", n, obs, e.v);
            end
            n++;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_illegal_halt();
        int n = 0;
        load_rom(16'hF000, 16'h4203, 16'h6000, 16'h4201);
        do_reset();
        p(0, 0, 16'h0000, 0, NONE);
        p(0, 0, 16'h0000, 0, NONE);
        p(0, 0, 16'hF000, 1, NONE);
        p(0, 0, 16'hF000, 1, ILF);
        p(0, 0, 16'hF000, 1, ILF);
        p(0, 0, 16'h4203, 2, LIW | ILF);
        p(0, 0, 16'h4203, 2, ILF);
        p(0, 0, 16'h4203, 2, ILF);
        p(0, 0, 16'h6000, 3, ILF);
        for (int i = 0; i < 6; i++) p(0, 1, 16'h6000, 3, HLT | ILF);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst = e.r;
            mem_ack = e.a;
            #1;
            checks++;
            if (obs !== e.v) begin
                errors++;
                $display("FAIL illegal_halt cyc%0d got %h exp %h", n, obs, e.v);
            end
            n++;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        int n = 0;
        load_rom(16'hF000, 16'h2A10, 16'h0000, 16'h0000);
        do_reset();
        p(0, 0, 16'h0000, 0, NONE);
        p(0, 0, 16'h0000, 0, NONE);
        p(0, 0, 16'hF000, 1, NONE);
        p(0, 0, 16'hF000, 1, ILF);
        p(0, 0, 16'hF000, 1, ILF);
        p(0, 0, 16'h2A10, 2, ILF);
        p(0, 0, 16'h2A10, 2, LDR | ILF);
        p(1, 0, 16'h2A10, 2, LDR | ILF);
        p(0, 1, 16'h0000, 0, NONE);
        p(0, 0, 16'h0000, 0, NONE);
        p(0, 0, 16'hF000, 1, NONE);
        p(0, 0, 16'hF000, 1, ILF);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst = e.r;
            mem_ack = e.a;
            #1;
            checks++;
            if (obs !== e.v) begin
                errors++;
                $display("FAIL rst_mid cyc%0d got %h exp %h", n, obs, e.v);
            end
            n++;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_pc_wrap();
        int n = 0;
        load_rom(16'h51FF, 16'h0000, 16'h0000, 16'h0000);
        rom[511] = 16'h4204;
        do_reset();
        p(0, 0, 16'h0000, 0, NONE);
        p(0, 0, 16'h0000, 0, NONE);
        p(0, 0, 16'h51FF, 1, NONE);
        p(0, 0, 16'h51FF, 511, NONE);
        p(0, 0, 16'h51FF, 511, NONE);
        p(0, 0, 16'h4204, 0, LIW);
        p(0, 0, 16'h4204, 0, NONE);
        p(0, 0, 16'h4204, 0, NONE);
        p(0, 0, 16'h51FF, 1, NONE);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst = e.r;
            mem_ack = e.a;
            #1;
            checks++;
            if (obs !== e.v) begin
                errors++;
                $display("FAIL pc_wrap cyc%0d got %h exp %h", n, obs, e.v);
            end
            n++;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        mem_ack = 1'b0;
        load_rom(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        test_reset();
        test_add();
        test_li_jmp();
        test_load();
        test_store_timeout();
        test_reset();
        test_illegal_halt();
        test_reset_mid_wait();
        test_pc_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
